sl_transmitter: RTL
===================

Name: sl_transmitter

Overview:
Serial-line (SL) word transmitter that drives the two-wire SL bus (zeroes line, ones line) consumed by SL_receiver. It accepts a 32-bit word over a valid/ready handshake and serialises the low BQ bits LSB-first, then an odd-parity bit, then a stop bit. Each bit is a low pulse on one or both lines followed by an idle-high gap. Config format and reset value match SL_receiver, so a tx/rx pair shares one config word.

Parameters:
CONFIG_WIDTH, 16, width of config word
LOW_LEN, 16, clock cycles each bit holds its line(s) low
HIGH_LEN, 16, clock cycles of idle-high gap after each bit

Ports:
clk  input  1  system clock (16 MHz)
rst_n  input  1  reset, asynchronous, active-low
tx_data  input  32  word to send; bits [BQ-1:0] used, upper bits ignored
tx_valid  input  1  tx_data valid
tx_ready  output  1  block can accept a word
wr_config_w  input  CONFIG_WIDTH  new config value
wr_enable  input  1  config write request
r_config_w  output  CONFIG_WIDTH  current config
serial_line_zeroes  output  1  SL zeroes line, idle high
serial_line_ones  output  1  SL ones line, idle high
tx_busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at end of frame

Behaviour:
- Interface: one clock (clk); rst_n is asynchronous, active-low.
- Reset values: both lines 1, tx_ready 1, tx_busy 0, tx_done 0, config 16'h0010 (BQ=8, PCE=0). All counters are 0.
- Config fields: bit0 = PCE (stored and read back only; tx always sends parity). Bits [6:1] = BQ (data bit count). The remaining bits are stored as written.
- Config write is accepted only when the state is IDLE, wr_enable=1, BQ is even, and 8 <= BQ <= 32. Otherwise config is unchanged and no error is flagged.
- tx_ready = (state==IDLE) & !wr_enable, so a config write wins over a word in the same cycle.
- Handshake: a word is accepted on the edge where tx_valid & tx_ready. At that edge:
  - tx_data[BQ-1:0] is latched into a shift register.
  - parity = ~^(tx_data[BQ-1:0]) is latched. Total ones including parity is odd; total zeros across BQ+1 bits is even.
  - The state goes to LOW and tx_busy becomes 1.
- Bit encoding during the LOW phase (outputs are registered):
  - data or parity 1: ones line=0, zeroes line=1.
  - data or parity 0: zeroes line=0, ones line=1.
  - stop bit: both lines 0.
- During HIGH and IDLE both lines are 1.
- Bit order: data bit 0 first, up to data bit BQ-1, then the parity bit, then the stop bit. That is BQ+2 bit slots in total.
- FSM states: IDLE, LOW, HIGH.
  - IDLE -> LOW on accept.
  - LOW holds for exactly LOW_LEN cycles, then -> HIGH.
  - HIGH holds for exactly HIGH_LEN cycles. Then -> LOW if the bit index is below BQ+1; otherwise -> IDLE.
- Counters: a 6-bit bit index (0..BQ+1) and a phase counter wide enough for max(LOW_LEN, HIGH_LEN).
- Latency: lines go low in the first cycle after the accept edge. The frame lasts (BQ+2)*(LOW_LEN+HIGH_LEN) cycles from that cycle.
- End of frame: tx_done=1 for the single cycle where the state re-enters IDLE. tx_busy=0 and tx_ready=1 (absent wr_enable) in that same cycle.
- Back-to-back frames: a word accepted in the tx_done cycle starts its LOW phase on the next cycle. The minimum inter-frame gap is HIGH_LEN+1 idle cycles.
- Config is sampled only at accept; a frame in flight is unaffected by later config.
- tx_valid while busy is ignored (no ready). wr_enable while busy is dropped, not queued.
- Reset mid-frame: lines return high immediately (async). The frame is abandoned and no tx_done is issued.

Test Plan:
- Reset: assert rst_n=0 mid-LOW -> both lines 1 within the same cycle; after release tx_ready=1, r_config_w=16'h0010, tx_done=0.
- Default config, tx_data=32'h000000A5 -> ones-line pulses for bits 0,2,5,7; zeroes-line pulses for bits 1,3,4,6. Parity slot drives ones=0 (popcount 4 gives parity 1). Stop slot drives both low. Each pulse is 16 low / 16 high. tx_done comes 320 cycles after the first low.
- Config writes: BQ=7 (16'h000E) rejected; BQ=6 (16'h000C) rejected; BQ=34 rejected; BQ=32 (16'h0041) accepted with r_config_w=16'h0041. A write during a frame leaves config unchanged.
- BQ=32, tx_data=32'hDEADBEEF, looped into SL_receiver with the same config -> receiver data_w=32'hDEADBEEF, status WRF=1, PEF=0, WLC=0, LEF=0.
- tx_valid held high for 3 words with BQ=8 -> each accepted in the tx_done cycle of the previous frame, 3 tx_done pulses, receiver gets all 3 words.
- wr_enable and tx_valid in the same idle cycle -> tx_ready=0, config updates, word accepted next cycle using the new BQ.

Source files
------------

// File: rtl/sl_transmitter_if.sv
// Word handshake and SL line bundle between a word source and sl_transmitter.
interface sl_transmitter_if;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        serial_line_zeroes;
  logic        serial_line_ones;
  logic        tx_busy;
  logic        tx_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, serial_line_zeroes, serial_line_ones, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, serial_line_zeroes, serial_line_ones, tx_busy, tx_done
  );
endinterface

// File: rtl/sl_transmitter.sv
// SL word transmitter: BQ data bits LSB-first, odd parity, stop; each bit is a LOW_LEN low pulse then HIGH_LEN idle-high.
// Lines go low the cycle after accept; a config write in IDLE takes priority over a word.
module sl_transmitter #(
  parameter int CONFIG_WIDTH = 16,
  parameter int LOW_LEN      = 16,
  parameter int HIGH_LEN     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sl_transmitter_if.slave         bus,
  input  logic [CONFIG_WIDTH-1:0] wr_config_w,
  input  logic                    wr_enable,
  output logic [CONFIG_WIDTH-1:0] r_config_w
);

  localparam int PMAX = (LOW_LEN > HIGH_LEN) ? LOW_LEN : HIGH_LEN;
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t                  state;
  logic [PW-1:0]           phase;
  logic [5:0]              bit_idx;
  logic [5:0]              frame_bq;
  logic [32:0]             shreg;
  logic [CONFIG_WIDTH-1:0] cfg;
  logic                    zeroes_q;
  logic                    ones_q;
  logic                    busy_q;
  logic                    done_q;

  logic [5:0]  cur_bq;
  logic [5:0]  new_bq;
  logic        cfg_ok;
  logic [32:0] mask;
  logic [32:0] masked;
  logic        par;
  logic [32:0] load;
  logic [6:0]  stop_idx;
  logic [6:0]  next_idx;

  assign cur_bq   = cfg[6:1];
  assign new_bq   = wr_config_w[6:1];
  assign cfg_ok   = ~new_bq[0] && (new_bq >= 6'd8) && (new_bq <= 6'd32);
  assign mask     = (33'd1 << cur_bq) - 33'd1;
  assign masked   = {1'b0, bus.tx_data} & mask;
  assign par      = ~^masked;
  // Parity rides in the shift register directly above the last data bit.
  assign load     = masked | ({32'd0, par} << cur_bq);
  assign stop_idx = {1'b0, frame_bq} + 7'd1;
  assign next_idx = {1'b0, bit_idx} + 7'd1;

  assign bus.tx_ready           = (state == IDLE) & ~wr_enable;
  assign bus.serial_line_zeroes = zeroes_q;
  assign bus.serial_line_ones   = ones_q;
  assign bus.tx_busy            = busy_q;
  assign bus.tx_done            = done_q;
  assign r_config_w             = cfg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      phase    <= '0;
      bit_idx  <= '0;
      frame_bq <= '0;
      shreg    <= '0;
      cfg      <= CONFIG_WIDTH'(16'h0010);
      zeroes_q <= 1'b1;
      ones_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_enable) begin
            if (cfg_ok) cfg <= wr_config_w;
          end else if (bus.tx_valid) begin
            state    <= LOW;
            phase    <= '0;
            bit_idx  <= '0;
            frame_bq <= cur_bq;
            shreg    <= load;
            busy_q   <= 1'b1;
            zeroes_q <= load[0];
            ones_q   <= ~load[0];
          end
        end
        LOW: begin
          if (phase == PW'(LOW_LEN - 1)) begin
            state    <= HIGH;
            phase    <= '0;
            shreg    <= shreg >> 1;
            zeroes_q <= 1'b1;
            ones_q   <= 1'b1;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        HIGH: begin
          if (phase == PW'(HIGH_LEN - 1)) begin
            phase <= '0;
            if ({1'b0, bit_idx} < stop_idx) begin
              state   <= LOW;
              bit_idx <= bit_idx + 6'd1;
              if (next_idx == stop_idx) begin
                zeroes_q <= 1'b0;
                ones_q   <= 1'b0;
              end else begin
                zeroes_q <= shreg[0];
                ones_q   <= ~shreg[0];
              end
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
